// File: rtl/fft_input_ctrl.sv
// Frame sequencer for the FFT input stage: paces an unbroken N-sample stream,
// drives the commutator select, and aligns output valid/last to the stage latency.
module fft_input_ctrl #(
  parameter int N   = 8,
  parameter int SEG = 1,
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       sel_1,
  output logic       out_valid,
  output logic       out_last,
  output logic       done,
  output logic       busy,
  output logic       err,
  output logic [7:0] frame_cnt
);

  // state | meaning
  // IDLE  | waiting for start, all outputs low
  // LOAD  | accepting samples, cnt = current sample index
  // FLUSH | draining LAT cycles of datapath latency
  // ERR   | stream gap seen, waiting for a restart
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, ERR} state_t;

  localparam int CW = $clog2(N);
  localparam int FW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SB = $clog2(SEG);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [FW-1:0]   fcnt, fcnt_nxt;
  logic [LAT-1:0]  vsh_v, vsh_l;
  logic            accept, last_smp, gap, flush_end;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fcnt_nxt  = fcnt;
    accept    = 1'b0;
    gap       = 1'b0;
    last_smp  = (cnt == CW'(N - 1));
    flush_end = (state == FLUSH) && (fcnt == '0);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          accept = 1'b1;
          if (last_smp) begin
            cnt_nxt   = '0;
            fcnt_nxt  = FW'(LAT - 1);
            state_nxt = FLUSH;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else begin
          // the commutator has no enable, so a missing sample corrupts the frame
          gap       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ERR;
        end
      end
      FLUSH: begin
        if (flush_end) state_nxt = IDLE;
        else           fcnt_nxt  = fcnt - FW'(1);
      end
      ERR: begin
        if (start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      fcnt      <= '0;
      vsh_v     <= '0;
      vsh_l     <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      fcnt  <= fcnt_nxt;
      if (gap) begin
        vsh_v <= '0;
        vsh_l <= '0;
      end else begin
        for (int i = LAT - 1; i > 0; i--) begin
          vsh_v[i] <= vsh_v[i-1];
          vsh_l[i] <= vsh_l[i-1];
        end
        vsh_v[0] <= accept;
        vsh_l[0] <= accept & last_smp;
      end
      if (flush_end) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign in_ready  = (state == LOAD);
  assign sel_1     = (state == LOAD) & cnt[SB];
  assign out_valid = vsh_v[LAT-1];
  assign out_last  = vsh_l[LAT-1];
  assign done      = flush_end;
  assign busy      = (state == LOAD) || (state == FLUSH);
  assign err       = (state == ERR);

endmodule

// File: tb/tb_fft_input_ctrl.sv
// Bench for fft_input_ctrl: two instances (SEG=1/LAT=1 and SEG=2/LAT=3) share the
// stimulus; per-cycle expectations come from the frame timing relations.
module tb_fft_input_ctrl;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;

  typedef struct packed {
    logic       in_ready;
    logic       sel_1;
    logic       out_valid;
    logic       out_last;
    logic       done;
    logic       busy;
    logic       err;
    logic [7:0] frame_cnt;
  } obs_t;

  typedef struct {
    logic start;
    logic in_valid;
    logic rst_mid;
    int   cyc;
    obs_t x1;
    obs_t x2;
  } vec_t;

  logic r1, s1, v1, l1, d1, b1, e1;
  logic r2, s2, v2, l2, d2, b2, e2;
  logic [7:0] f1, f2;
  obs_t a1, a2;

  assign a1 = {r1, s1, v1, l1, d1, b1, e1, f1};
  assign a2 = {r2, s2, v2, l2, d2, b2, e2, f2};

  fft_input_ctrl #(.N(N), .SEG(1), .LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(r1), .sel_1(s1), .out_valid(v1), .out_last(l1),
    .done(d1), .busy(b1), .err(e1), .frame_cnt(f1)
  );

  fft_input_ctrl #(.N(N), .SEG(2), .LAT(3)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(r2), .sel_1(s2), .out_valid(v2), .out_last(l2),
    .done(d2), .busy(b2), .err(e2), .frame_cnt(f2)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string phase = "init";
  vec_t  sbq[$];
  vec_t  tbl[13];

  // expected outputs c cycles after a start accepted in IDLE/ERR at c=0
  function automatic obs_t fexp(int c, int seg, int lat, logic [7:0] fc0);
    obs_t o;
    o = '0;
    o.frame_cnt = (c > N + lat) ? fc0 + 8'd1 : fc0;
    if (c >= 1 && c <= N) begin
      o.in_ready = 1'b1;
      o.sel_1    = (((c - 1) / seg) % 2) == 1;
    end
    o.out_valid = (c >= 1 + lat) && (c <= N + lat);
    o.out_last  = (c == N + lat);
    o.done      = (c == N + lat);
    o.busy      = (c >= 1) && (c <= N + lat);
    return o;
  endfunction

  function automatic obs_t errobs(logic [7:0] fc);
    obs_t o;
    o = '0;
    o.err = 1'b1;
    o.frame_cnt = fc;
    return o;
  endfunction

  function automatic vec_t mk(logic s, logic iv, logic rm, int c, obs_t x1, obs_t x2);
    vec_t v;
    v.start = s;
    v.in_valid = iv;
    v.rst_mid = rm;
    v.cyc = c;
    v.x1 = x1;
    v.x2 = x2;
    return v;
  endfunction

  task automatic chk(input string nm, input int c, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s cyc %0d: got {rdy,sel,ov,ol,done,busy,err,fc}=%b_%b_%b_%b_%b_%b_%b_%0d want %b_%b_%b_%b_%b_%b_%b_%0d",
               phase, nm, c, act.in_ready, act.sel_1, act.out_valid, act.out_last, act.done,
               act.busy, act.err, act.frame_cnt, exp.in_ready, exp.sel_1, exp.out_valid,
               exp.out_last, exp.done, exp.busy, exp.err, exp.frame_cnt);
    end
  endtask

  // drives one cycle (entered 1 time unit after a rising edge), samples on the falling edge
  task automatic step(input vec_t v);
    vec_t e;
    rst      = 1'b0;
    start    = v.start;
    in_valid = v.in_valid;
    sbq.push_back(v);
    if (v.rst_mid) begin
      #2;
      rst = 1'b1;
    end
    @(negedge clk);
    e = sbq.pop_front();
    chk("lat1", e.cyc, a1, e.x1);
    chk("lat3", e.cyc, a2, e.x2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    obs_t x1, x2;
    for (int c = 0; c < 13; c++)
      tbl[c] = mk(c == 0, 1'b1, 1'b0, c, fexp(c, 1, 1, 8'd0), fexp(c, 2, 3, 8'd0));

    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    step(mk(1'b0, 1'b1, 1'b1, 0, '0, '0));
    step(mk(1'b0, 1'b1, 1'b0, 1, '0, '0));

    phase = "frame";
    for (int c = 0; c < 13; c++) step(tbl[c]);

    phase = "start_ignored";
    for (int c = 0; c < 13; c++)
      step(mk(c == 0 || c == 3 || c == 9, 1'b1, 1'b0, c,
              fexp(c, 1, 1, 8'd1), fexp(c, 2, 3, 8'd1)));

    phase = "gap";
    for (int c = 0; c < 20; c++) begin
      if (c <= 4) begin
        x1 = fexp(c, 1, 1, 8'd2);
        x2 = fexp(c, 2, 3, 8'd2);
      end else if (c <= 7) begin
        x1 = errobs(8'd2);
        x2 = errobs(8'd2);
      end else begin
        x1 = fexp(c - 7, 1, 1, 8'd2);
        x2 = fexp(c - 7, 2, 3, 8'd2);
      end
      step(mk(c == 0 || c == 7, c != 4, 1'b0, c, x1, x2));
    end

    phase = "rst_mid";
    for (int c = 0; c < 5; c++)
      step(mk(c == 0, 1'b1, 1'b0, c, fexp(c, 1, 1, 8'd3), fexp(c, 2, 3, 8'd3)));
    step(mk(1'b0, 1'b1, 1'b1, 5, '0, '0));

    phase = "after_rst";
    for (int c = 0; c < 13; c++) step(tbl[c]);

    phase = "back_to_back";
    step(mk(1'b0, 1'b0, 1'b1, 0, '0, '0));
    for (int c = 0; c <= 3072; c++)
      step(mk(1'b1, 1'b1, 1'b0, c,
              fexp(c % 10, 1, 1, 8'(c / 10)), fexp(c % 12, 2, 3, 8'(c / 12))));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
